// File: rtl/mesh_unloader.sv
// Streams words 0..N-1 out of the result RAM onto a valid/ready stream,
// absorbing the 1-cycle RAM read latency in a small credit-controlled FIFO.
module mesh_unloader #(
  parameter int AW         = 9,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   word_count,
  output logic          ram_en,
  output logic [AW-1:0] ram_a,
  output logic [3:0]    ram_we,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     n_q;
  logic [AW:0]     issue_cnt_q;
  logic [AW:0]     n_in;
  logic            rd_valid_q, rd_last_q;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_bits_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            busy_q, done_q;
  logic            pop, push, issue, last_issue, credit;
  int              count_after;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign m_valid = (count_q != '0);
  assign m_data  = mem[rd_ptr_q];
  assign m_last  = m_valid & last_bits_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;
  assign push    = rd_valid_q;
  assign n_in    = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

  // Credit must see this cycle's pop to sustain 1 word/cycle with two
  // entries, so the read strobe is decoded from registered state plus pop.
  assign count_after = int'(count_q) + int'(rd_valid_q) - int'(pop);
  assign credit      = (count_after < FIFO_DEPTH);
  assign last_issue  = (issue_cnt_q == n_q - 1'b1);
  assign issue       = (state_q == S_READ) && credit && !rst;

  assign ram_en = issue;
  assign ram_a  = issue_cnt_q[AW-1:0];
  assign ram_we = '0;
  assign ram_di = '0;
  assign busy   = busy_q;
  assign done   = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (n_in == '0) ? S_DRAIN : S_READ;
      S_READ:  if (issue && last_issue) state_d = S_DRAIN;
      S_DRAIN: if (count_after == 0) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      issue_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      last_bits_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_READ) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_FIN);
      if (state_q == S_IDLE && start) begin
        n_q         <= n_in;
        issue_cnt_q <= '0;
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
      rd_valid_q <= issue;
      rd_last_q  <= issue && last_issue;
      if (push) begin
        mem[wr_ptr_q]         <= ram_do;
        last_bits_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= CW'(count_after);
    end
  end

endmodule

// File: tb/tb_mesh_unloader.sv
// Scoreboard bench for mesh_unloader: expected words are queued at start and
// checked as the stream hands them off, alongside per-cycle protocol checks.
module tb_mesh_unloader;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, start, m_ready;
  logic [AW:0]   word_count;
  logic          ram_en, m_valid, m_last, busy, done;
  logic [AW-1:0] ram_a;
  logic [3:0]    ram_we;
  logic [DW-1:0] ram_di, ram_do, m_data;

  mesh_unloader #(.AW(AW), .DW(DW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di),
    .ram_do(ram_do), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [512];
  always @(posedge clk) if (ram_en) ram_do <= ram[ram_a];

  int checks = 0, failures = 0;
  logic [DW:0] exp_q [$];
  logic [DW:0] exp_w, stall_word;
  bit   mon_en = 0, stall_pend = 0;
  int   occ = 0, inflight = 0, hs_count = 0, next_addr = 0, mon_pop = 0;

  // Protocol monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) if (mon_en) begin
    mon_pop = (m_valid === 1'b1 && m_ready === 1'b1) ? 1 : 0;
    checks++;
    if (m_valid !== (occ != 0)) begin
      failures++; $display("FAIL m_valid_occ: got %b want %b", m_valid, occ != 0);
    end
    checks++;
    if (ram_we !== 4'b0 || ram_di !== '0) begin
      failures++; $display("FAIL ram_write: we=%h di=%h want 0", ram_we, ram_di);
    end
    if (stall_pend) begin
      checks++;
      if (m_valid !== 1'b1 || {m_last, m_data} !== stall_word) begin
        failures++;
        $display("FAIL stall_hold: got v=%b %h want v=1 %h", m_valid, {m_last, m_data}, stall_word);
      end
    end
    if (ram_en === 1'b1) begin
      checks++;
      if (occ + inflight - mon_pop >= 2) begin
        failures++; $display("FAIL credit: read with occ=%0d inflight=%0d pop=%0d", occ, inflight, mon_pop);
      end
      checks++;
      if (int'(ram_a) !== next_addr) begin
        failures++; $display("FAIL addr_order: got %0d want %0d", ram_a, next_addr);
      end
      next_addr++;
    end
    if (mon_pop == 1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL extra_word: got %h want none", {m_last, m_data});
      end else begin
        exp_w = exp_q.pop_front();
        if ({m_last, m_data} !== exp_w) begin
          failures++; $display("FAIL word: got last/data %h want %h", {m_last, m_data}, exp_w);
        end
      end
      hs_count++;
    end
    stall_pend = (m_valid === 1'b1 && m_ready !== 1'b1);
    stall_word = {m_last, m_data};
    occ        = occ + inflight - mon_pop;
    inflight   = (ram_en === 1'b1) ? 1 : 0;
  end

  task automatic fill_ram(input logic [DW-1:0] base, input logic [DW-1:0] step);
    for (int i = 0; i < 512; i++) ram[i] = base + DW'(i) * step;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), ram[i]});
  endtask

  task automatic do_start(input int wc);
    @(posedge clk); #1;
    start = 1'b1; word_count = (AW+1)'(wc);
    push_exp((wc > 512) ? 512 : wc);
    next_addr = 0; hs_count = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL %s: done not seen within %0d cycles", name, limit); end
  endtask

  task automatic check_count(input string name, input int want);
    @(negedge clk); #1;
    checks++;
    if (hs_count != want || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: words %0d left %0d want words %0d left 0", name, hs_count, exp_q.size(), want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; word_count = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_a, m_valid, m_last, busy, done} !== 14'b0) begin
      failures++;
      $display("FAIL reset_state: en=%b a=%0d v=%b l=%b busy=%b done=%b want all 0",
               ram_en, ram_a, m_valid, m_last, busy, done);
    end
    mon_en = 1;
  endtask

  task automatic test_basic();
    fill_ram(32'hA0, 32'h1);
    m_ready = 1'b1;
    do_start(4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if ({ram_en, m_valid, busy, done} !== {(c <= 4), (c >= 3 && c <= 6), (c <= 6), (c == 7)}) begin
        failures++;
        $display("FAIL basic_timing c%0d: en/v/busy/done=%b%b%b%b want %b%b%b%b", c, ram_en, m_valid,
                 busy, done, (c <= 4), (c >= 3 && c <= 6), (c <= 6), (c == 7));
      end
    end
    check_count("basic_count", 4);
  endtask

  task automatic test_stall();
    bit seen = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    fill_ram(32'h1234_0000, 32'h11);
    m_ready = 1'b1;
    do_start(8);
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #1 m_ready = pat[c % 4];
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL stall_done: done not seen within 100 cycles"); end
    m_ready = 1'b1;
    check_count("stall_count", 8);
  endtask

  task automatic test_zero();
    m_ready = 1'b1;
    do_start(0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, m_valid, ram_en} !== {(c == 1), (c == 2), 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL zero_words c%0d: busy/done/v/en=%b%b%b%b want %b%b00", c, busy, done, m_valid,
                 ram_en, (c == 1), (c == 2));
      end
    end
  endtask

  task automatic test_clamp();
    fill_ram(32'hC000_0000, 32'h7);
    m_ready = 1'b1;
    do_start(600);
    wait_done(700, "clamp_done");
    check_count("clamp_count", 512);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    fill_ram(32'hA0, 32'h1);
    m_ready = 1'b1;
    do_start(10);
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk); #1;
      if (hs_count >= 3) seen = 1;
    end
    @(posedge clk); #1 m_ready = 1'b0;
    checks++;
    if (hs_count != 3) begin failures++; $display("FAIL mid_sent: got %0d want 3", hs_count); end
    @(posedge clk); #1 rst = 1'b1; mon_en = 0;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete(); occ = 0; inflight = 0; stall_pend = 0; next_addr = 0; hs_count = 0;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_a, m_valid, m_last, busy, done} !== 14'b0) begin
      failures++;
      $display("FAIL mid_reset_state: en=%b a=%0d v=%b l=%b busy=%b done=%b want all 0",
               ram_en, ram_a, m_valid, m_last, busy, done);
    end
    mon_en = 1;
    m_ready = 1'b1;
    do_start(2);
    wait_done(20, "mid_restart_done");
    check_count("mid_restart_count", 2);
  endtask

  task automatic test_ignore_start();
    fill_ram(32'h5500, 32'h3);
    m_ready = 1'b1;
    do_start(5);
    @(posedge clk); #1 start = 1'b1; word_count = (AW+1)'(1);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy: got %b want 1", busy); end
    wait_done(30, "ignore_done");
    @(negedge clk);
    checks++;
    if ({busy, ram_en, m_valid} !== 3'b000) begin
      failures++; $display("FAIL ignore_idle: busy/en/v=%b%b%b want 000", busy, ram_en, m_valid);
    end
    check_count("ignore_count", 5);
  endtask

  task automatic test_back_to_back();
    fill_ram(32'hB0, 32'h1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; word_count = (AW+1)'(3);
    push_exp(3); next_addr = 0; hs_count = 0;
    wait_done(20, "b2b_first_done");
    @(posedge clk); #1;
    push_exp(3); next_addr = 0;
    @(negedge clk);
    checks++;
    if ({busy, ram_en} !== 2'b00) begin
      failures++; $display("FAIL b2b_idle: busy/en=%b%b want 00", busy, ram_en);
    end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ram_en, ram_a} !== {2'b11, 9'd0}) begin
      failures++; $display("FAIL b2b_restart: busy/en=%b%b a=%0d want 11 a=0", busy, ram_en, ram_a);
    end
    wait_done(20, "b2b_second_done");
    check_count("b2b_count", 6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_clamp();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
